dma64_mem_responder: RTL

Memory-side responder for the 64-bit DMA interface driven by the accelerator: it accepts read/write control requests, streams read beats out, and absorbs write beats into an internal single-port 64-bit memory. It stands in for the system DMA engine and DRAM in block-level simulation and FPGA bring-up. It also has a host port for preloading weights/images and dumping results.

---
 rtl/dma64_pkg.sv | 14 +
 rtl/dma64_rd_fifo2.sv | 45 ++++
 rtl/dma64_mem_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dma64_pkg.sv
// Shared types and constants for the 64-bit DMA memory responder.
// Pulled in by the responder top and by its read-path FIFO.
package dma64_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } dma_state_e;

    localparam int         DMA_BEAT_W  = 64;
    localparam logic [2:0] DMA_SIZE_64 = 3'b011;

endpackage

// File: rtl/dma64_rd_fifo2.sv
// Two-entry beat FIFO on the read path. The head register holds its value
// while the consumer stalls, which keeps read data stable under backpressure.
module dma64_rd_fifo2
    import dma64_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DMA_BEAT_W-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DMA_BEAT_W-1:0] head_o,
    output logic [1:0]            count_o
);

    logic [DMA_BEAT_W-1:0] ent_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) ent_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                ent_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
        end
    end

    assign head_o  = ent_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/dma64_mem_responder.sv
// Memory-side DMA responder: serves read/write bursts from a single-port
// 64-bit RAM and exposes a host port for preload and dump while idle.
module dma64_mem_responder
    import dma64_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dma_read_ctrl_valid,
    input  logic [31:0]           dma_read_ctrl_data_index,
    input  logic [31:0]           dma_read_ctrl_data_length,
    input  logic [2:0]            dma_read_ctrl_data_size,
    output logic                  dma_read_ctrl_ready,
    output logic                  dma_read_chnl_valid,
    output logic [DMA_BEAT_W-1:0] dma_read_chnl_data,
    input  logic                  dma_read_chnl_ready,
    input  logic                  dma_write_ctrl_valid,
    input  logic [31:0]           dma_write_ctrl_data_index,
    input  logic [31:0]           dma_write_ctrl_data_length,
    input  logic [2:0]            dma_write_ctrl_data_size,
    output logic                  dma_write_ctrl_ready,
    input  logic                  dma_write_chnl_valid,
    input  logic [DMA_BEAT_W-1:0] dma_write_chnl_data,
    output logic                  dma_write_chnl_ready,
    input  logic                  host_we,
    input  logic                  host_re,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DMA_BEAT_W-1:0] host_wdata,
    output logic [DMA_BEAT_W-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  busy,
    output logic                  wrap_err
);

    dma_state_e            state_q;
    logic [ADDR_W-1:0]     base_q;
    logic [31:0]           len_q, issue_cnt_q, done_cnt_q;
    logic [2:0]            size_q;
    logic                  inflight_q, wrap_err_q, host_rvalid_q;
    logic [DMA_BEAT_W-1:0] mem [MEM_WORDS];
    logic [DMA_BEAT_W-1:0] mem_q;

    logic                  idle, rd_hs, wr_hs, wr_beat, rd_pop, rd_issue;
    logic                  host_en, mem_we;
    logic [1:0]            fifo_count;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DMA_BEAT_W-1:0] mem_wdata;
    logic [31:0]           req_index, req_len;
    logic [2:0]            req_size;
    logic [32:0]           req_end;
    logic                  unused_ok;

    // Readies are gated by rst so nothing handshakes while reset is held.
    assign idle                 = (state_q == IDLE) && !rst;
    assign dma_read_ctrl_ready  = idle;
    assign dma_write_ctrl_ready = idle && !dma_read_ctrl_valid;
    assign rd_hs                = dma_read_ctrl_valid && dma_read_ctrl_ready;
    assign wr_hs                = dma_write_ctrl_valid && dma_write_ctrl_ready;
    assign dma_write_chnl_ready = (state_q == WR) && !rst;
    assign wr_beat              = dma_write_chnl_valid && dma_write_chnl_ready;
    assign dma_read_chnl_valid  = (fifo_count != 2'd0);
    assign rd_pop               = dma_read_chnl_valid && dma_read_chnl_ready;
    assign host_en              = idle && !rd_hs && !wr_hs;
    assign mem_we               = wr_beat || (host_en && host_we);

    // A pop in this cycle frees a slot, which keeps beats back-to-back.
    assign rd_issue = (state_q == RD) && !rst && (issue_cnt_q < len_q) &&
                      (({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, rd_pop}));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned and infers a latch.
        req_index = dma_write_ctrl_data_index;
        req_len   = dma_write_ctrl_data_length;
        req_size  = dma_write_ctrl_data_size;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        if (rd_hs) begin
            req_index = dma_read_ctrl_data_index;
            req_len   = dma_read_ctrl_data_length;
            req_size  = dma_read_ctrl_data_size;
        end
        case (state_q)
            RD: mem_addr = base_q + issue_cnt_q[ADDR_W-1:0];
            WR: begin
                mem_addr  = base_q + done_cnt_q[ADDR_W-1:0];
                mem_wdata = dma_write_chnl_data;
            end
            default: ;
        endcase
    end

    assign req_end = {1'b0, req_index} + {1'b0, req_len};

    // NOTE: the RAM array has no reset; contents survive rst and only the
    // control state around it is cleared.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_q <= mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            len_q         <= '0;
            issue_cnt_q   <= '0;
            done_cnt_q    <= '0;
            size_q        <= DMA_SIZE_64;
            inflight_q    <= 1'b0;
            wrap_err_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            inflight_q    <= rd_issue;
            host_rvalid_q <= host_en && host_re;
            case (state_q)
                IDLE: if (rd_hs || wr_hs) begin
                    base_q      <= req_index[ADDR_W-1:0];
                    len_q       <= req_len;
                    size_q      <= req_size;
                    issue_cnt_q <= '0;
                    done_cnt_q  <= '0;
                    if (req_end > 33'(MEM_WORDS)) wrap_err_q <= 1'b1;
                    if (req_len != 32'd0) state_q <= rd_hs ? RD : WR;
                end
                RD: begin
                    if (rd_issue) issue_cnt_q <= issue_cnt_q + 32'd1;
                    if (rd_pop) begin
                        done_cnt_q <= done_cnt_q + 32'd1;
                        if (done_cnt_q + 32'd1 == len_q) state_q <= IDLE;
                    end
                end
                WR: if (wr_beat) begin
                    done_cnt_q <= done_cnt_q + 32'd1;
                    if (done_cnt_q + 32'd1 == len_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dma64_rd_fifo2 u_rd_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (mem_q),
        .pop_i       (rd_pop),
        .head_o      (dma_read_chnl_data),
        .count_o     (fifo_count)
    );

    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rvalid_q ? mem_q : '0;
    assign busy        = (state_q != IDLE);
    assign wrap_err    = wrap_err_q;
    // Element size is recorded with each request but does not alter behaviour.
    assign unused_ok   = ^size_q;

endmodule
